// File: rtl/trace_packer.sv
// Tracer-side packer: folds n trace bits per cycle into WIDTH-bit store words,
// and unpacks memory words from the logger into an n-bit valid/ready stream.
package dtb_pkg;
  typedef enum logic [1:0] {
    TRACE_MODE     = 2'd0,
    RW_STREAM_MODE = 2'd1,
    R_STREAM_MODE  = 2'd2,
    W_STREAM_MODE  = 2'd3
  } mode_e;
endpackage

module trace_packer
  import dtb_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int NTRACE_BITS = 2,
  parameter int MAX_TRACE   = 8
) (
  input  logic                     CLK_I,
  input  logic                     RST_NI,
  input  logic [1:0]               MODE_I,
  input  logic [NTRACE_BITS-1:0]   NTRACE_I,
  input  logic [MAX_TRACE-1:0]     TRACE_I,
  input  logic                     TRG_I,
  input  logic                     TRG_DELAYED_I,
  input  logic                     STORE_PERM_I,
  output logic                     STORE_O,
  output logic [WIDTH-1:0]         DATA_O,
  output logic [$clog2(WIDTH)-1:0] EVENT_POS_O,
  output logic                     TRG_EVENT_O,
  output logic                     OVERFLOW_O,
  output logic                     LOAD_REQUEST_O,
  input  logic                     LOAD_GRANT_I,
  input  logic [WIDTH-1:0]         DATA_I,
  output logic [MAX_TRACE-1:0]     STREAM_O,
  output logic                     STREAM_VALID_O,
  input  logic                     STREAM_READY_I
);

  localparam int PW      = $clog2(WIDTH);
  localparam int LOG_MAX = $clog2(MAX_TRACE);

  typedef enum logic [1:0] {RD_EMPTY, RD_WAIT, RD_FULL} rd_state_e;

  logic [1:0]             mode_q;
  logic [NTRACE_BITS-1:0] ntrace_q;
  logic [NTRACE_BITS-1:0] log2n;
  int unsigned            n_lanes;
  logic [MAX_TRACE-1:0]   lane_mask;
  logic [PW-1:0]          last_idx;
  logic                   flush;
  logic                   halted_q;
  logic                   halt_now;
  logic                   cap_en;
  logic                   word_done;
  logic                   stream_en;
  logic [WIDTH-1:0]       cap_word;
  logic [WIDTH-1:0]       cap_next;
  logic [PW-1:0]          cnt;
  rd_state_e              rd_state;
  logic [WIDTH-1:0]       rword;
  logic [PW-1:0]          rcnt;

  // Lane geometry comes from the registered n, so it only moves after a flush.
  always_comb begin
    flush = (MODE_I != mode_q) || (NTRACE_I != ntrace_q);
    if (int'(ntrace_q) > LOG_MAX) log2n = NTRACE_BITS'(LOG_MAX);
    else                          log2n = ntrace_q;
    n_lanes   = 32'd1 << log2n;
    lane_mask = MAX_TRACE'((64'd1 << n_lanes) - 64'd1);
    last_idx  = PW'((WIDTH >> log2n) - 1);
    halt_now  = (mode_q == TRACE_MODE) && TRG_DELAYED_I;
    cap_en    = !flush && !halted_q && !halt_now && (mode_q != R_STREAM_MODE);
    word_done = cap_en && (cnt == last_idx);
    stream_en = !flush && ((mode_q == RW_STREAM_MODE) || (mode_q == R_STREAM_MODE));
    cap_next  = (cap_word >> n_lanes) |
                (WIDTH'(TRACE_I & lane_mask) << (WIDTH - int'(n_lanes)));
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      mode_q      <= '0;
      ntrace_q    <= '0;
      cap_word    <= '0;
      cnt         <= '0;
      halted_q    <= 1'b0;
      STORE_O     <= 1'b0;
      DATA_O      <= '0;
      EVENT_POS_O <= '0;
      TRG_EVENT_O <= 1'b0;
      OVERFLOW_O  <= 1'b0;
    end else begin
      mode_q   <= MODE_I;
      ntrace_q <= NTRACE_I;
      STORE_O  <= 1'b0;
      if (halt_now) halted_q <= 1'b1;
      if (flush || halt_now) begin
        cap_word <= '0;
        cnt      <= '0;
      end else if (cap_en) begin
        cap_word <= cap_next;
        cnt      <= word_done ? '0 : cnt + 1'b1;
        if (word_done) begin
          if (STORE_PERM_I) begin
            STORE_O <= 1'b1;
            DATA_O  <= cap_next;
          end else begin
            OVERFLOW_O <= 1'b1;
          end
        end
        if (TRG_I && !TRG_EVENT_O) begin
          TRG_EVENT_O <= 1'b1;
          EVENT_POS_O <= cnt << log2n;
        end
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      rd_state       <= RD_EMPTY;
      rword          <= '0;
      rcnt           <= '0;
      LOAD_REQUEST_O <= 1'b0;
      STREAM_VALID_O <= 1'b0;
    end else if (!stream_en) begin
      rd_state       <= RD_EMPTY;
      rword          <= '0;
      rcnt           <= '0;
      LOAD_REQUEST_O <= 1'b0;
      STREAM_VALID_O <= 1'b0;
    end else begin
      unique case (rd_state)
        RD_EMPTY: begin
          LOAD_REQUEST_O <= 1'b1;
          rd_state       <= RD_WAIT;
        end
        RD_WAIT: begin
          if (LOAD_GRANT_I) begin
            rword          <= DATA_I;
            rcnt           <= '0;
            LOAD_REQUEST_O <= 1'b0;
            STREAM_VALID_O <= 1'b1;
            rd_state       <= RD_FULL;
          end
        end
        RD_FULL: begin
          if (STREAM_READY_I) begin
            rword <= rword >> n_lanes;
            if (rcnt == last_idx) begin
              rcnt           <= '0;
              STREAM_VALID_O <= 1'b0;
              rd_state       <= RD_EMPTY;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
        end
        default: rd_state <= RD_EMPTY;
      endcase
    end
  end

  // Decoded purely from registers, so the slice cannot move while stalled.
  assign STREAM_O = rword[MAX_TRACE-1:0] & lane_mask & {MAX_TRACE{STREAM_VALID_O}};

endmodule

// File: tb/tb_trace_packer.sv
// Self-checking bench for trace_packer (WIDTH=16, MAX_TRACE=8): vector table for
// packing/trigger/overflow, scoreboards for stores and stream slices, corner sequences.
module tb_trace_packer;
  import dtb_pkg::*;

  localparam int WIDTH       = 16;
  localparam int NTRACE_BITS = 2;
  localparam int MAX_TRACE   = 8;

  logic                   CLK_I = 1'b0;
  logic                   RST_NI;
  logic [1:0]             MODE_I;
  logic [NTRACE_BITS-1:0] NTRACE_I;
  logic [MAX_TRACE-1:0]   TRACE_I;
  logic                   TRG_I;
  logic                   TRG_DELAYED_I;
  logic                   STORE_PERM_I;
  logic                   STORE_O;
  logic [WIDTH-1:0]       DATA_O;
  logic [3:0]             EVENT_POS_O;
  logic                   TRG_EVENT_O;
  logic                   OVERFLOW_O;
  logic                   LOAD_REQUEST_O;
  logic                   LOAD_GRANT_I;
  logic [WIDTH-1:0]       DATA_I;
  logic [MAX_TRACE-1:0]   STREAM_O;
  logic                   STREAM_VALID_O;
  logic                   STREAM_READY_I;

  trace_packer #(
    .WIDTH(WIDTH), .NTRACE_BITS(NTRACE_BITS), .MAX_TRACE(MAX_TRACE)
  ) dut (
    .CLK_I(CLK_I), .RST_NI(RST_NI), .MODE_I(MODE_I), .NTRACE_I(NTRACE_I),
    .TRACE_I(TRACE_I), .TRG_I(TRG_I), .TRG_DELAYED_I(TRG_DELAYED_I),
    .STORE_PERM_I(STORE_PERM_I), .STORE_O(STORE_O), .DATA_O(DATA_O),
    .EVENT_POS_O(EVENT_POS_O), .TRG_EVENT_O(TRG_EVENT_O), .OVERFLOW_O(OVERFLOW_O),
    .LOAD_REQUEST_O(LOAD_REQUEST_O), .LOAD_GRANT_I(LOAD_GRANT_I), .DATA_I(DATA_I),
    .STREAM_O(STREAM_O), .STREAM_VALID_O(STREAM_VALID_O), .STREAM_READY_I(STREAM_READY_I)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    logic [7:0]  trace;
    logic        trg;
    logic        perm;
    logic        push;
    logic [15:0] word;
    logic        exp_store;
    logic        exp_trg;
    logic [3:0]  exp_pos;
    logic        exp_ovf;
  } vec_t;

  vec_t        vecs [16];
  logic [15:0] store_q [$];
  logic [7:0]  stream_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          store_cnt;
  logic        got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic sample(input logic [7:0] t, input logic trg);
    TRACE_I = t;
    TRG_I   = trg;
    tick();
  endtask

  task automatic apply_reset();
    RST_NI = 1'b0;
    store_q.delete();
    stream_q.delete();
    repeat (2) tick();
    RST_NI = 1'b1;
  endtask

  // Scoreboard side: compare every store strobe and every accepted slice.
  always @(negedge CLK_I) begin
    if (RST_NI && STORE_O) begin
      check("store_expected", 32'(store_q.size() != 0), 32'd1);
      if (store_q.size() != 0) check("store_data", 32'(DATA_O), 32'(store_q.pop_front()));
    end
    if (RST_NI && STREAM_VALID_O && STREAM_READY_I) begin
      check("slice_expected", 32'(stream_q.size() != 0), 32'd1);
      if (stream_q.size() != 0) check("slice_data", 32'(STREAM_O), 32'(stream_q.pop_front()));
    end
  end

  initial begin
    RST_NI = 1'b0; MODE_I = TRACE_MODE; NTRACE_I = 2'd2; TRACE_I = '0; TRG_I = 1'b0;
    TRG_DELAYED_I = 1'b0; STORE_PERM_I = 1'b1; LOAD_GRANT_I = 1'b0; DATA_I = '0;
    STREAM_READY_I = 1'b0;

    //           trace  trg   perm  push  word     st    trg   pos   ovf
    vecs[0]  = '{8'h01, 1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 4'd0, 1'b0};
    vecs[1]  = '{8'h02, 1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 4'd0, 1'b0};
    vecs[2]  = '{8'h03, 1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 4'd0, 1'b0};
    vecs[3]  = '{8'h04, 1'b0, 1'b1, 1'b1, 16'h4321, 1'b1, 1'b0, 4'd0, 1'b0};
    vecs[4]  = '{8'h05, 1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 4'd0, 1'b0};
    vecs[5]  = '{8'h06, 1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 4'd0, 1'b0};
    vecs[6]  = '{8'h07, 1'b1, 1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 4'd8, 1'b0};
    vecs[7]  = '{8'h08, 1'b1, 1'b1, 1'b1, 16'h8765, 1'b1, 1'b1, 4'd8, 1'b0};
    vecs[8]  = '{8'h09, 1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 4'd8, 1'b0};
    vecs[9]  = '{8'h0A, 1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 1'b1, 4'd8, 1'b0};
    vecs[10] = '{8'h0B, 1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 4'd8, 1'b0};
    vecs[11] = '{8'h0C, 1'b1, 1'b0, 1'b0, 16'h0,    1'b0, 1'b1, 4'd8, 1'b1};
    vecs[12] = '{8'hF1, 1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 4'd8, 1'b1};
    vecs[13] = '{8'h01, 1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 4'd8, 1'b1};
    vecs[14] = '{8'h31, 1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 4'd8, 1'b1};
    vecs[15] = '{8'h0F, 1'b0, 1'b1, 1'b1, 16'hF111, 1'b1, 1'b1, 4'd8, 1'b1};

    // Reset state
    repeat (2) tick();
    check("rst_store",   32'(STORE_O), 32'd0);
    check("rst_data",    32'(DATA_O), 32'd0);
    check("rst_trg",     32'(TRG_EVENT_O), 32'd0);
    check("rst_pos",     32'(EVENT_POS_O), 32'd0);
    check("rst_ovf",     32'(OVERFLOW_O), 32'd0);
    check("rst_req",     32'(LOAD_REQUEST_O), 32'd0);
    check("rst_valid",   32'(STREAM_VALID_O), 32'd0);
    check("rst_stream",  32'(STREAM_O), 32'd0);
    RST_NI = 1'b1;
    tick();  // n differs from the reset copy: flush cycle
    check("flush_no_store", 32'(STORE_O), 32'd0);

    // Packing, trigger position, overflow, upper trace bits ignored
    for (int i = 0; i < 16; i++) begin
      TRACE_I = vecs[i].trace; TRG_I = vecs[i].trg; STORE_PERM_I = vecs[i].perm;
      if (vecs[i].push) store_q.push_back(vecs[i].word);
      tick();
      check($sformatf("vec%0d_store", i), 32'(STORE_O), 32'(vecs[i].exp_store));
      check($sformatf("vec%0d_trg", i),   32'(TRG_EVENT_O), 32'(vecs[i].exp_trg));
      check($sformatf("vec%0d_pos", i),   32'(EVENT_POS_O), 32'(vecs[i].exp_pos));
      check($sformatf("vec%0d_ovf", i),   32'(OVERFLOW_O), 32'(vecs[i].exp_ovf));
    end
    TRG_I = 1'b0; STORE_PERM_I = 1'b1;
    tick();
    check("table_stores_drained", 32'(store_q.size()), 32'd0);
    check("data_held", 32'(DATA_O), 32'h0000F111);

    // Trigger on the completing sample, then trace_mode halt
    apply_reset();
    tick();
    sample(8'h01, 1'b0); sample(8'h02, 1'b0); sample(8'h03, 1'b0);
    store_q.push_back(16'h4321);
    sample(8'h04, 1'b1);
    check("edge_trg_store", 32'(STORE_O), 32'd1);
    check("edge_trg_event", 32'(TRG_EVENT_O), 32'd1);
    check("edge_trg_pos",   32'(EVENT_POS_O), 32'd12);
    sample(8'h05, 1'b0); sample(8'h06, 1'b0);
    TRG_DELAYED_I = 1'b1;
    sample(8'h07, 1'b0);
    TRG_DELAYED_I = 1'b0;
    store_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      sample(8'($urandom_range(0, 255)), 1'b0);
      if (STORE_O) store_cnt++;
    end
    check("halt_no_store", 32'(store_cnt), 32'd0);
    check("halt_sb_drained", 32'(store_q.size()), 32'd0);
    apply_reset();
    check("halt_rst_trg", 32'(TRG_EVENT_O), 32'd0);
    tick();
    sample(8'h09, 1'b0); sample(8'h0A, 1'b0); sample(8'h0B, 1'b0);
    store_q.push_back(16'hCBA9);
    sample(8'h0C, 1'b0);
    check("resume_store", 32'(STORE_O), 32'd1);

    // n change mid-word: flush keeps trigger info, new word restarts at cnt=0
    sample(8'h01, 1'b0);
    sample(8'h02, 1'b1);
    check("pre_flush_pos", 32'(EVENT_POS_O), 32'd4);
    NTRACE_I = 2'd3;
    sample(8'h55, 1'b0);
    check("nchg_flush_store", 32'(STORE_O), 32'd0);
    check("nchg_trg_kept",    32'(TRG_EVENT_O), 32'd1);
    check("nchg_pos_kept",    32'(EVENT_POS_O), 32'd4);
    sample(8'hAB, 1'b0);
    check("nchg_half_store", 32'(STORE_O), 32'd0);
    store_q.push_back(16'hCDAB);
    sample(8'hCD, 1'b0);
    check("nchg_store", 32'(STORE_O), 32'd1);
    tick();
    check("nchg_sb_drained", 32'(store_q.size()), 32'd0);

    // Stream: r_stream_mode, n=8
    MODE_I = R_STREAM_MODE; NTRACE_I = 2'd3;
    apply_reset();
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (LOAD_REQUEST_O) got = 1'b1;
    end
    check("stream_req", 32'(got), 32'd1);
    LOAD_GRANT_I = 1'b1; DATA_I = 16'hBEEF;
    stream_q.push_back(8'hEF); stream_q.push_back(8'hBE);
    tick();
    LOAD_GRANT_I = 1'b0;
    check("grant_req_drop", 32'(LOAD_REQUEST_O), 32'd0);
    check("grant_valid",    32'(STREAM_VALID_O), 32'd1);
    check("grant_slice0",   32'(STREAM_O), 32'hEF);
    for (int i = 0; i < 3; i++) begin
      LOAD_GRANT_I = (i == 1); DATA_I = 16'h1234;
      tick();
      check($sformatf("stall%0d_slice", i), 32'(STREAM_O), 32'hEF);
      check($sformatf("stall%0d_valid", i), 32'(STREAM_VALID_O), 32'd1);
    end
    LOAD_GRANT_I = 1'b0;
    STREAM_READY_I = 1'b1;
    tick();
    check("slice1",       32'(STREAM_O), 32'hBE);
    check("slice1_noreq", 32'(LOAD_REQUEST_O), 32'd0);
    tick();
    STREAM_READY_I = 1'b0;
    check("drained_valid", 32'(STREAM_VALID_O), 32'd0);
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      if (LOAD_REQUEST_O) got = 1'b1;
    end
    check("req_reassert", 32'(got), 32'd1);
    check("stream_sb_drained", 32'(stream_q.size()), 32'd0);
    NTRACE_I = 2'd2;
    tick();
    check("flush_req_withdrawn", 32'(LOAD_REQUEST_O), 32'd0);

    // rw_stream_mode: concurrent capture + request, then async reset in RD_WAIT
    MODE_I = RW_STREAM_MODE; NTRACE_I = 2'd2;
    apply_reset();
    tick();
    sample(8'h01, 1'b1);
    sample(8'h02, 1'b0); sample(8'h03, 1'b0);
    store_q.push_back(16'h4321);
    sample(8'h04, 1'b0);
    check("rw_store", 32'(STORE_O), 32'd1);
    check("rw_req",   32'(LOAD_REQUEST_O), 32'd1);
    check("rw_trg",   32'(TRG_EVENT_O), 32'd1);
    sample(8'h05, 1'b0);
    #2 RST_NI = 1'b0;
    #1;
    check("async_data",  32'(DATA_O), 32'd0);
    check("async_req",   32'(LOAD_REQUEST_O), 32'd0);
    check("async_trg",   32'(TRG_EVENT_O), 32'd0);
    check("async_store", 32'(STORE_O), 32'd0);
    check("async_sb_drained", 32'(store_q.size()), 32'd0);
    tick();
    RST_NI = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
